// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage producing the register-file write port and retire count
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_wr,
  input  logic [1:0]       in_wb_sel,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [2:0]       in_funct3,
  input  logic             dmem_rvalid,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             wrEn,
  output logic [4:0]       Rdst,
  output logic [XLEN-1:0]  RWrdata,
  output logic             retire_valid,
  output logic [CNT_W-1:0] retire_count
);
  typedef enum logic {IDLE, WAIT_LOAD} state_t;
  state_t          state;
  logic [4:0]      l_rd;
  logic            l_reg_wr;
  logic [2:0]      l_funct3;
  logic [1:0]      l_addr;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] src_val;
  assign in_ready = (state == IDLE);
  always_comb begin
    lane_b   = 8'(dmem_rdata >> {l_addr, 3'b000});
    lane_h   = l_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_val = (l_funct3 == 3'b000) ? {{24{lane_b[7]}}, lane_b} :
               (l_funct3 == 3'b001) ? {{16{lane_h[15]}}, lane_h} :
               (l_funct3 == 3'b100) ? {24'd0, lane_b} :
               (l_funct3 == 3'b101) ? {16'd0, lane_h} : dmem_rdata;
    src_val  = (in_wb_sel == 2'b00) ? in_alu_result : in_pc + 32'd4;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wrEn         <= 1'b0;
      Rdst         <= '0;
      RWrdata      <= '0;
      retire_valid <= 1'b0;
      retire_count <= '0;
      l_rd         <= '0;
      l_reg_wr     <= 1'b0;
      l_funct3     <= '0;
      l_addr       <= '0;
    end else begin
      wrEn         <= 1'b0;
      retire_valid <= 1'b0;
      if (state == IDLE && in_valid) begin
        if (in_wb_sel == 2'b01) begin
          l_rd     <= in_rd;
          l_reg_wr <= in_reg_wr;
          l_funct3 <= in_funct3;
          l_addr   <= in_alu_result[1:0];
          state    <= WAIT_LOAD;
        end else begin
          wrEn         <= in_reg_wr && (in_rd != 5'd0) && (in_wb_sel != 2'b11);
          retire_valid <= 1'b1;
          retire_count <= retire_count + 1'b1;
          if (in_wb_sel != 2'b11) begin
            Rdst    <= in_rd;
            RWrdata <= src_val;
          end
        end
      end else if (state == WAIT_LOAD && dmem_rvalid) begin
        wrEn         <= l_reg_wr && (l_rd != 5'd0);
        Rdst         <= l_rd;
        RWrdata      <= load_val;
        retire_valid <= 1'b1;
        retire_count <= retire_count + 1'b1;
        state        <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed self-checking bench for writeback_stage
module tb_writeback_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic        in_reg_wr = 1'b0;
  logic [1:0]  in_wb_sel = '0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_pc = '0;
  logic [2:0]  in_funct3 = '0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wrEn;
  logic [4:0]  Rdst;
  logic [31:0] RWrdata;
  logic        retire_valid;
  logic [31:0] retire_count;
  int checks = 0;
  int errors = 0;
  writeback_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_reg_wr(in_reg_wr), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_pc(in_pc), .in_funct3(in_funct3),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wrEn(wrEn),
    .Rdst(Rdst), .RWrdata(RWrdata), .retire_valid(retire_valid),
    .retire_count(retire_count)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc);
    in_valid = 1'b1; in_rd = rd; in_reg_wr = rw; in_wb_sel = sel;
    in_alu_result = alu; in_pc = pc;
    step();
    in_valid = 1'b0;
  endtask
  task automatic do_load(input string tag, input logic [4:0] rd, input logic [1:0] addr,
                         input logic [2:0] f3, input logic [31:0] data, input int dly);
    in_funct3 = f3;
    issue(rd, 1'b1, 2'b01, {30'h0000_1000, addr}, 32'h0);
    for (int i = 0; i < dly; i++) begin
      chk({tag, "_ready_low"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_no_wr"}, {31'd0, wrEn}, 32'd0);
      if (i < dly - 1) step();
    end
    dmem_rvalid = 1'b1; dmem_rdata = data;
    step();
    dmem_rvalid = 1'b0; dmem_rdata = 32'hDEAD_BEEF;
    chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_wren"}, {31'd0, wrEn}, 32'd1);
    chk({tag, "_rdst"}, {27'd0, Rdst}, {27'd0, rd});
  endtask
  initial begin
    step();
    step();
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wren", {31'd0, wrEn}, 32'd0);
    chk("rst_rdst", {27'd0, Rdst}, 32'd0);
    chk("rst_data", RWrdata, 32'd0);
    chk("rst_retire", {31'd0, retire_valid}, 32'd0);
    chk("rst_count", retire_count, 32'd0);
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_rd = 5'd5; in_reg_wr = 1'b1; in_wb_sel = 2'b00;
    in_alu_result = 32'h1234;
    step();
    chk("alu1_wren", {31'd0, wrEn}, 32'd1);
    chk("alu1_rdst", {27'd0, Rdst}, 32'd5);
    chk("alu1_data", RWrdata, 32'h1234);
    chk("alu1_ready", {31'd0, in_ready}, 32'd1);
    in_rd = 5'd6; in_alu_result = 32'hABCD;
    step();
    in_valid = 1'b0;
    chk("alu2_wren", {31'd0, wrEn}, 32'd1);
    chk("alu2_rdst", {27'd0, Rdst}, 32'd6);
    chk("alu2_data", RWrdata, 32'hABCD);
    chk("alu2_count", retire_count, 32'd2);
    step();
    chk("idle_wren", {31'd0, wrEn}, 32'd0);
    chk("idle_retire", {31'd0, retire_valid}, 32'd0);
    chk("idle_hold_rdst", {27'd0, Rdst}, 32'd6);
    chk("idle_hold_data", RWrdata, 32'hABCD);
    dmem_rvalid = 1'b1;
    step();
    dmem_rvalid = 1'b0;
    chk("idle_rvalid_wren", {31'd0, wrEn}, 32'd0);
    chk("idle_rvalid_count", retire_count, 32'd2);
    do_load("lb", 5'd7, 2'b11, 3'b000, 32'h80FF_7F01, 3);
    chk("lb_data", RWrdata, 32'hFFFF_FF80);
    chk("lb_retire", {31'd0, retire_valid}, 32'd1);
    chk("lb_count", retire_count, 32'd3);
    do_load("lhu", 5'd8, 2'b10, 3'b101, 32'h80FF_7F01, 1);
    chk("lhu_data", RWrdata, 32'h0000_80FF);
    do_load("lw", 5'd9, 2'b10, 3'b010, 32'h80FF_7F01, 1);
    chk("lw_data", RWrdata, 32'h80FF_7F01);
    do_load("lh", 5'd10, 2'b11, 3'b001, 32'h80FF_7F01, 2);
    chk("lh_data", RWrdata, 32'hFFFF_80FF);
    do_load("lbu", 5'd11, 2'b00, 3'b100, 32'h80FF_7F81, 1);
    chk("lbu_data", RWrdata, 32'h0000_0081);
    do_load("lb1", 5'd12, 2'b01, 3'b000, 32'h80FF_7F01, 1);
    chk("lb1_data", RWrdata, 32'h0000_007F);
    do_load("lh0", 5'd13, 2'b00, 3'b001, 32'h1234_8001, 1);
    chk("lh0_data", RWrdata, 32'hFFFF_8001);
    chk("loads_count", retire_count, 32'd9);
    issue(5'd1, 1'b1, 2'b10, 32'h0, 32'hFFFF_FFFC);
    chk("jal_wren", {31'd0, wrEn}, 32'd1);
    chk("jal_rdst", {27'd0, Rdst}, 32'd1);
    chk("jal_data", RWrdata, 32'h0);
    issue(5'd0, 1'b1, 2'b10, 32'h0, 32'h0000_0100);
    chk("jal_x0_wren", {31'd0, wrEn}, 32'd0);
    chk("jal_x0_retire", {31'd0, retire_valid}, 32'd1);
    chk("jal_x0_rdst", {27'd0, Rdst}, 32'd0);
    chk("jal_x0_data", RWrdata, 32'h0000_0104);
    chk("jal_count", retire_count, 32'd11);
    issue(5'd9, 1'b1, 2'b11, 32'h5555, 32'h0);
    chk("store_wren", {31'd0, wrEn}, 32'd0);
    chk("store_retire", {31'd0, retire_valid}, 32'd1);
    chk("store_count", retire_count, 32'd12);
    issue(5'd4, 1'b0, 2'b00, 32'h7777, 32'h0);
    chk("nowr_wren", {31'd0, wrEn}, 32'd0);
    chk("nowr_count", retire_count, 32'd13);
    in_funct3 = 3'b010;
    issue(5'd15, 1'b1, 2'b01, 32'h2000, 32'h0);
    chk("rl_ready_low", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #2;
    chk("rl_async_count", retire_count, 32'd0);
    chk("rl_async_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    step();
    dmem_rvalid = 1'b0;
    chk("rl_wren", {31'd0, wrEn}, 32'd0);
    chk("rl_retire", {31'd0, retire_valid}, 32'd0);
    chk("rl_count", retire_count, 32'd0);
    chk("rl_ready", {31'd0, in_ready}, 32'd1);
    chk("rl_data", RWrdata, 32'd0);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
